// File: rtl/pushbutton_event_sequencer.sv
// Pushbutton PIO owner: programs irq_mask, services edge_capture
// interrupts and queues masked button events for a consumer.
module pushbutton_event_sequencer #(
  parameter int              BTN_W      = 4,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [BTN_W-1:0] MASK_RESET = 4'hF
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  input  logic [BTN_W-1:0] cfg_mask,
  input  logic             cfg_mask_update,
  output logic             event_valid,
  output logic [BTN_W-1:0] event_data,
  input  logic             event_ready,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic             busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT_MASK,
    ST_IDLE,
    ST_WR_MASK,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_CLR,
    ST_PUSH
  } state_t;

  state_t           r_state;
  logic [1:0]       r_addr;
  logic             r_cs;
  logic             r_wr_n;
  logic [BTN_W-1:0] r_wdata;
  logic [BTN_W-1:0] r_mask;
  logic [BTN_W-1:0] r_cap;
  logic             r_pend;
  logic [BTN_W-1:0] r_pend_val;

  logic [BTN_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic [BTN_W-1:0] w_cap;
  logic             w_mask_take;
  logic             w_valid;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_accept;
  logic             w_drop;
  logic             w_unused;

  assign w_cap       = pio_readdata[BTN_W-1:0] & r_mask;
  assign w_mask_take = (r_state == ST_IDLE) && r_pend;
  assign w_valid     = (r_count != '0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_push      = (r_state == ST_PUSH);
  assign w_pop       = w_valid && event_ready;
  assign w_accept    = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;
  assign w_unused    = ^pio_readdata[31:BTN_W];

  assign pio_address    = r_addr;
  assign pio_chipselect = r_cs;
  assign pio_write_n    = r_wr_n;
  assign pio_writedata  = {{(32-BTN_W){1'b0}}, r_wdata};
  assign event_valid    = w_valid;
  assign event_data     = w_valid ? r_mem[r_rptr] : '0;
  assign overflow       = r_ovf;
  assign busy           = (r_state != ST_IDLE);

  // Bus sequencer: each state's drive is loaded on entry, so it is
  // visible for exactly the clock the FSM spends in that state.
  // ST_RESET only holds the bus idle until the first clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RESET;
      r_addr  <= 2'd0;
      r_cs    <= 1'b0;
      r_wr_n  <= 1'b1;
      r_wdata <= '0;
      r_mask  <= MASK_RESET;
      r_cap   <= '0;
    end else begin
      unique case (r_state)
        ST_RESET: begin
          r_state <= ST_INIT_MASK;
          r_cs    <= 1'b1;
          r_wr_n  <= 1'b0;
          r_addr  <= 2'd2;
          r_wdata <= r_mask;
        end
        ST_INIT_MASK, ST_WR_MASK: begin
          r_state <= ST_IDLE;
          r_cs    <= 1'b0;
          r_wr_n  <= 1'b1;
        end
        ST_IDLE: begin
          if (r_pend) begin
            r_state <= ST_WR_MASK;
            r_mask  <= r_pend_val;
            r_cs    <= 1'b1;
            r_wr_n  <= 1'b0;
            r_addr  <= 2'd2;
            r_wdata <= r_pend_val;
          end else if (pio_irq) begin
            r_state <= ST_RD_ADDR;
            r_cs    <= 1'b1;
            r_wr_n  <= 1'b1;
            r_addr  <= 2'd3;
          end
        end
        ST_RD_ADDR: begin
          r_state <= ST_RD_DATA;
          r_cs    <= 1'b0;
        end
        ST_RD_DATA: begin
          r_state <= ST_CLR;
          r_cap   <= w_cap;
          r_cs    <= 1'b1;
          r_wr_n  <= 1'b0;
          r_addr  <= 2'd3;
          r_wdata <= w_cap;
        end
        ST_CLR: begin
          r_state <= (r_cap == '0) ? ST_IDLE : ST_PUSH;
          r_cs    <= 1'b0;
          r_wr_n  <= 1'b1;
        end
        ST_PUSH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_RESET;
        end
      endcase
    end
  end

  // Pending mask request; a new pulse overrides the pending value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend     <= 1'b0;
      r_pend_val <= '0;
    end else if (cfg_mask_update) begin
      r_pend     <= 1'b1;
      r_pend_val <= cfg_mask;
    end else if (w_mask_take) begin
      r_pend     <= 1'b0;
    end
  end

  // Event storage; contents need no reset, the pointers gate them.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wptr] <= r_cap;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + PW'(1);
      if (w_pop)    r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_accept) - CW'(w_pop);
      if (w_drop)            r_ovf <= 1'b1;
      else if (overflow_clr) r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pushbutton_event_sequencer.sv
// Bench for pushbutton_event_sequencer with an attached PIO model
// and a queue-based model of the event stream.
module tb_pushbutton_event_sequencer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;
  logic [3:0]  cfg_mask = 4'h0;
  logic        cfg_mask_update = 1'b0;
  logic        event_valid;
  logic [3:0]  event_data;
  logic        event_ready = 1'b0;
  logic        overflow;
  logic        overflow_clr = 1'b0;
  logic        busy;

  int total = 0;
  int passed = 0;

  pushbutton_event_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .pio_address(pio_address),
    .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata),
    .pio_irq(pio_irq),
    .cfg_mask(cfg_mask),
    .cfg_mask_update(cfg_mask_update),
    .event_valid(event_valid),
    .event_data(event_data),
    .event_ready(event_ready),
    .overflow(overflow),
    .overflow_clr(overflow_clr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // PIO slave: write-1-to-clear edge_capture, clear beats a same-cycle edge.
  logic [3:0] ec, irq_mask;
  logic [3:0] press = 4'h0;
  logic       w_wr, w_rd;
  assign w_wr = pio_chipselect && !pio_write_n;
  assign w_rd = pio_chipselect && pio_write_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ec <= 4'h0; irq_mask <= 4'h0; pio_readdata <= 32'h0;
    end else begin
      ec <= (ec | press) &
            ~((w_wr && pio_address == 2'd3) ? pio_writedata[3:0] : 4'h0);
      if (w_wr && pio_address == 2'd2) irq_mask <= pio_writedata[3:0];
      if (w_rd)
        pio_readdata <= (pio_address == 2'd3) ? {28'h0, ec} :
                        (pio_address == 2'd2) ? {28'h0, irq_mask} : 32'h0;
    end
  end
  assign pio_irq = |(ec & irq_mask);

  // Bus transaction log: {is_write, addr, data}.
  logic [6:0] blog[$];
  int hi_bad = 0;
  always @(posedge clk) begin
    if (reset_n && pio_chipselect) begin
      blog.push_back({!pio_write_n, pio_address,
                      pio_write_n ? 4'h0 : pio_writedata[3:0]});
      if (!pio_write_n && pio_writedata[31:4] != 28'h0) hi_bad++;
    end
  end

  // Reference model: expected events in order, overflow, active mask.
  logic [3:0] mq[$];
  logic       ovf_m = 1'b0;
  logic [3:0] mask_m = 4'hF;

  function automatic void m_push(logic [3:0] v);
    if (v == 4'h0) return;
    if (mq.size() < D) mq.push_back(v);
    else ovf_m = 1'b1;
  endfunction

  task automatic press_btn(input logic [3:0] v);
    press = v;
    @(negedge clk);
    press = 4'h0;
  endtask

  task automatic wait_service(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!pio_irq && !busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pop_one(output logic v, output logic [3:0] d);
    v = event_valid;
    d = event_data;
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (pio_address !== 2'd0) $display("FAIL rst_addr got %0d want 0", pio_address); else passed++;
    total++; if (pio_chipselect !== 1'b0) $display("FAIL rst_cs got %b want 0", pio_chipselect); else passed++;
    total++; if (pio_write_n !== 1'b1) $display("FAIL rst_wr_n got %b want 1", pio_write_n); else passed++;
    total++; if (pio_writedata !== 32'h0) $display("FAIL rst_wdata got %h want 0", pio_writedata); else passed++;
    total++; if (event_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", event_valid); else passed++;
    total++; if (event_data !== 4'h0) $display("FAIL rst_data got %h want 0", event_data); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b want 0", overflow); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL rst_busy got %b want 1", busy); else passed++;
    blog.delete();
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0 ||
        pio_address !== 2'd2 || pio_writedata !== 32'hF)
      $display("FAIL init_write got cs=%b wr_n=%b a=%0d d=%h want cs=1 wr_n=0 a=2 d=f",
               pio_chipselect, pio_write_n, pio_address, pio_writedata);
    else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL init_busy got %b want 0", busy); else passed++;
    total++; if (pio_chipselect !== 1'b0) $display("FAIL init_idle_cs got %b want 0", pio_chipselect); else passed++;
    total++; if (irq_mask !== 4'hF) $display("FAIL init_mask got %h want f", irq_mask); else passed++;
    total++; if (blog.size() != 1 || blog[0] !== 7'b1_10_1111)
      $display("FAIL init_log got n=%0d want one write a=2 d=f", blog.size()); else passed++;
    repeat (3) @(negedge clk);
    total++; if (event_valid !== 1'b0) $display("FAIL init_valid got %b want 0", event_valid); else passed++;
  endtask

  task automatic test_single;
    int  lat;
    logic v;
    logic [3:0] d;
    blog.delete();
    press_btn(4'h4);
    total++; if (pio_irq !== 1'b1) $display("FAIL single_irq got %b want 1", pio_irq); else passed++;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (event_valid === 1'b1 && lat < 0) lat = k;
    end
    total++; if (lat != 5) $display("FAIL single_latency got %0d want 5", lat); else passed++;
    total++; if (event_data !== 4'h4) $display("FAIL single_data got %h want 4", event_data); else passed++;
    total++; if (ec !== 4'h0) $display("FAIL single_ec got %h want 0", ec); else passed++;
    total++;
    if (blog.size() != 2 || blog[0] !== 7'b0_11_0000 || blog[1] !== 7'b1_11_0100)
      $display("FAIL single_log got n=%0d want rd a=3 then wr a=3 d=4", blog.size());
    else passed++;
    pop_one(v, d);
    total++; if (v !== 1'b1 || d !== 4'h4) $display("FAIL single_pop got v=%b d=%h want v=1 d=4", v, d); else passed++;
    total++; if (event_valid !== 1'b0) $display("FAIL single_empty got %b want 0", event_valid); else passed++;
  endtask

  task automatic test_overflow;
    bit ok;
    logic v;
    logic [3:0] d, b, e;
    for (int i = 0; i < 6; i++) begin
      b = (i == 0) ? 4'h9 : 4'($urandom_range(1, 15));
      press_btn(b);
      wait_service(ok);
      total++; if (!ok) $display("FAIL ovf_service got timeout want idle"); else passed++;
      m_push(b & mask_m);
    end
    total++; if (overflow !== ovf_m) $display("FAIL ovf_flag got %b want %b", overflow, ovf_m); else passed++;
    while (mq.size() > 0) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      e = mq.pop_front();
      pop_one(v, d);
      total++; if (v !== 1'b1 || d !== e) $display("FAIL ovf_pop got v=%b d=%h want v=1 d=%h", v, d, e); else passed++;
    end
    total++; if (event_valid !== 1'b0) $display("FAIL ovf_drained got %b want 0", event_valid); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else passed++;
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    ovf_m = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %b want 0", overflow); else passed++;
  endtask

  task automatic test_full_push_pop;
    bit ok;
    logic v;
    logic [3:0] d, b, e;
    for (int i = 0; i < D; i++) begin
      b = 4'($urandom_range(1, 15));
      press_btn(b);
      wait_service(ok);
      total++; if (!ok) $display("FAIL full_service got timeout want idle"); else passed++;
      m_push(b & mask_m);
    end
    b = 4'($urandom_range(1, 15));
    press_btn(b);
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL full_push_busy got %b want 1", busy); else passed++;
    e = mq.pop_front();
    mq.push_back(b & mask_m);
    pop_one(v, d);
    total++; if (v !== 1'b1 || d !== e) $display("FAIL full_same_pop got v=%b d=%h want v=1 d=%h", v, d, e); else passed++;
    wait_service(ok);
    total++; if (!ok) $display("FAIL full_service2 got timeout want idle"); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL full_no_drop got %b want 0", overflow); else passed++;
    while (mq.size() > 0) begin
      e = mq.pop_front();
      pop_one(v, d);
      total++; if (v !== 1'b1 || d !== e) $display("FAIL full_pop got v=%b d=%h want v=1 d=%h", v, d, e); else passed++;
    end
    total++; if (event_valid !== 1'b0) $display("FAIL full_count got %b want 0 after 4 pops", event_valid); else passed++;
  endtask

  task automatic test_random;
    bit ok;
    logic v;
    logic [3:0] d, b, e;
    for (int it = 0; it < 20; it++) begin
      b = 4'($urandom_range(0, 15));
      press_btn(b);
      wait_service(ok);
      total++; if (!ok) $display("FAIL rnd_service got timeout want idle"); else passed++;
      m_push(b & mask_m);
      repeat ($urandom_range(0, 2)) begin
        if (mq.size() == 0) begin
          pop_one(v, d);
          total++; if (v !== 1'b0) $display("FAIL rnd_empty_pop got v=%b want 0", v); else passed++;
        end else begin
          e = mq.pop_front();
          pop_one(v, d);
          total++; if (v !== 1'b1 || d !== e) $display("FAIL rnd_pop got v=%b d=%h want v=1 d=%h", v, d, e); else passed++;
        end
      end
      total++; if (overflow !== ovf_m) $display("FAIL rnd_ovf got %b want %b", overflow, ovf_m); else passed++;
    end
    while (mq.size() > 0) begin
      e = mq.pop_front();
      pop_one(v, d);
      total++; if (v !== 1'b1 || d !== e) $display("FAIL rnd_drain got v=%b d=%h want v=1 d=%h", v, d, e); else passed++;
    end
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    ovf_m = 1'b0;
  endtask

  task automatic test_mask_update;
    bit ok;
    logic v;
    logic [3:0] d, b, e;
    blog.delete();
    b = 4'($urandom_range(1, 15));
    press_btn(b);
    repeat (2) @(negedge clk);
    cfg_mask = 4'h1;
    cfg_mask_update = 1'b1;
    @(negedge clk);
    cfg_mask_update = 1'b0;
    wait_service(ok);
    repeat (4) @(negedge clk);
    total++; if (!ok) $display("FAIL mask_service got timeout want idle"); else passed++;
    m_push(b & mask_m);
    mask_m = 4'h1;
    total++; if (irq_mask !== 4'h1) $display("FAIL mask_pio got %h want 1", irq_mask); else passed++;
    total++; if (blog.size() == 0 || blog[$] !== 7'b1_10_0001)
      $display("FAIL mask_write got n=%0d want last wr a=2 d=1", blog.size()); else passed++;
    blog.delete();
    press_btn(4'h2);
    repeat (6) @(negedge clk);
    total++; if (pio_irq !== 1'b0) $display("FAIL mask_irq got %b want 0", pio_irq); else passed++;
    total++; if (blog.size() != 0) $display("FAIL mask_quiet got n=%0d want 0", blog.size()); else passed++;
    press_btn(4'h3);
    wait_service(ok);
    total++; if (!ok) $display("FAIL mask_service2 got timeout want idle"); else passed++;
    m_push(4'h3 & mask_m);
    total++; if (ec !== 4'h2) $display("FAIL mask_ec got %h want 2", ec); else passed++;
    while (mq.size() > 0) begin
      e = mq.pop_front();
      pop_one(v, d);
      total++; if (v !== 1'b1 || d !== e) $display("FAIL mask_pop got v=%b d=%h want v=1 d=%h", v, d, e); else passed++;
    end
    total++; if (event_valid !== 1'b0) $display("FAIL mask_empty got %b want 0", event_valid); else passed++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      press_btn(4'h1);
      wait_service(ok);
      total++; if (!ok) $display("FAIL rmid_service got timeout want idle"); else passed++;
      m_push(4'h1 & mask_m);
    end
    total++; if (event_valid !== 1'b1) $display("FAIL rmid_queued got %b want 1", event_valid); else passed++;
    press_btn(4'h1);
    repeat (3) @(negedge clk);
    total++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0 || pio_address !== 2'd3)
      $display("FAIL rmid_clr got cs=%b wr_n=%b a=%0d want cs=1 wr_n=0 a=3",
               pio_chipselect, pio_write_n, pio_address);
    else passed++;
    reset_n = 1'b0;
    #1;
    mq.delete();
    mask_m = 4'hF;
    total++; if (event_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", event_valid); else passed++;
    total++; if (pio_chipselect !== 1'b0) $display("FAIL rmid_cs got %b want 0", pio_chipselect); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL rmid_busy got %b want 1", busy); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0 ||
        pio_address !== 2'd2 || pio_writedata !== 32'hF)
      $display("FAIL rmid_init got cs=%b wr_n=%b a=%0d d=%h want cs=1 wr_n=0 a=2 d=f",
               pio_chipselect, pio_write_n, pio_address, pio_writedata);
    else passed++;
    repeat (6) @(negedge clk);
    total++; if (event_valid !== 1'b0) $display("FAIL rmid_after got %b want 0", event_valid); else passed++;
    total++; if (hi_bad != 0) $display("FAIL wdata_upper got %0d writes want 0", hi_bad); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_mask_update();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
